// File: rtl/isa_pkg.sv
// Shared definitions for the ISA memory-cycle engine: state encoding,
// bus park values, default phase lengths and counter sizing.
package isa_pkg;

  // One state per phase of an 8-bit ISA memory cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    SETUP = 3'd2,
    CMD   = 3'd3,
    WAIT  = 3'd4,
    HOLD  = 3'd5,
    RECOV = 3'd6
  } isa_state_t;

  // Value the address bus rests at between cycles.
  localparam logic [23:0] ISA_ADDR_PARK = 24'hFFFFFF;
  // Value driven on the write-data lines and returned on a timed-out read.
  localparam logic [7:0]  ISA_DATA_PARK = 8'hFF;

  // Default phase lengths in 50 MHz clk cycles.
  localparam int BALE_CYC_DEF    = 2;
  localparam int SETUP_CYC_DEF   = 2;
  localparam int CMD_CYC_DEF     = 6;
  localparam int HOLD_CYC_DEF    = 2;
  localparam int RECOV_CYC_DEF   = 4;
  localparam int TIMEOUT_CYC_DEF = 256;

  // Width of a down-counter that is loaded with (len - 1); never below 1 bit.
  function automatic int cnt_width(input int len);
    if (len <= 1) begin
      return 1;
    end
    return $clog2(len);
  endfunction

  // Counter width for the default timing, governed by the WAIT timeout.
  localparam int CNT_W = cnt_width(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/isa_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset
// value so an inactive-low line can come out of reset in its idle state.
module isa_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/isa_cycle_engine.sv
// ISA-side stage of the PC104 bridge: takes one decoded memory access at a
// time and runs a complete, timed 8-bit ISA memory cycle from a single
// down-counter and FSM. All bus outputs are registered, so every output
// change lands on the same edge as the state change that causes it.
module isa_cycle_engine
  import isa_pkg::*;
#(
  parameter int BALE_CYC    = BALE_CYC_DEF,
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int CMD_CYC     = CMD_CYC_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int RECOV_CYC   = RECOV_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [23:0] isa_addr,
  output logic [7:0]  isa_data_o,
  output logic        isa_data_oe,
  input  logic [7:0]  isa_data_i,
  output logic        bale,
  output logic        mem_r,
  output logic        mem_w,
  input  logic        io_chrdy,
  output logic        busy
);

  // The timeout is normally the longest phase, but size the counter for the
  // longest of all so unusual parameter sets cannot truncate a load value.
  localparam int MAX_A   = (BALE_CYC  > SETUP_CYC)   ? BALE_CYC  : SETUP_CYC;
  localparam int MAX_B   = (CMD_CYC   > HOLD_CYC)    ? CMD_CYC   : HOLD_CYC;
  localparam int MAX_C   = (RECOV_CYC > TIMEOUT_CYC) ? RECOV_CYC : TIMEOUT_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_LEN = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW      = cnt_width(MAX_LEN);

  // Counter load values: each phase counts (length - 1) down to zero.
  localparam logic [CW-1:0] LD_BALE  = CW'(BALE_CYC - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] LD_WAIT  = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_RECOV = CW'(RECOV_CYC - 1);

  isa_state_t    r_state;
  isa_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_write;

  logic          w_chrdy_s;
  logic          w_accept;
  logic          w_to_hold;
  logic          w_timeout;
  logic          w_write_sel;
  logic          w_bus_active;
  logic          w_cmd_active;

  logic [23:0]   r_isa_addr,    w_isa_addr_next;
  logic [7:0]    r_isa_data_o,  w_isa_data_o_next;
  logic          r_isa_data_oe, w_isa_data_oe_next;
  logic          r_bale,        w_bale_next;
  logic          r_mem_r,       w_mem_r_next;
  logic          r_mem_w,       w_mem_w_next;
  logic          r_req_ready,   w_req_ready_next;
  logic          r_busy,        w_busy_next;
  logic          r_rsp_valid,   w_rsp_valid_next;
  logic          r_rsp_timeout, w_rsp_timeout_next;
  logic [7:0]    r_rsp_rdata,   w_rsp_rdata_next;

  // IOCHRDY is asynchronous to clk; it resets to "ready".
  isa_sync #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_chrdy_sync (
    .clk (clk),
    .rst (rst),
    .i_d (io_chrdy),
    .o_q (w_chrdy_s)
  );

  // Next-state, counter and registered-output decode for the cycle FSM.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_to_hold    = 1'b0;
    w_timeout    = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = ADDR;
          w_cnt_next   = LD_BALE;
        end
      end
      ADDR: begin
        if (r_cnt == '0) begin
          w_state_next = SETUP;
          w_cnt_next   = LD_SETUP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_next = CMD;
          w_cnt_next   = LD_CMD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      CMD: begin
        // IOCHRDY is only looked at in the last minimum-width command cycle.
        if (r_cnt == '0) begin
          if (w_chrdy_s) begin
            w_state_next = HOLD;
            w_cnt_next   = LD_HOLD;
            w_to_hold    = 1'b1;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = LD_WAIT;
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      WAIT: begin
        // A ready seen in the final timeout cycle still counts as a normal end.
        if (w_chrdy_s) begin
          w_state_next = HOLD;
          w_cnt_next   = LD_HOLD;
          w_to_hold    = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_next = HOLD;
          w_cnt_next   = LD_HOLD;
          w_to_hold    = 1'b1;
          w_timeout    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_next = RECOV;
          w_cnt_next   = LD_RECOV;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      RECOV: begin
        if (r_cnt == '0) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Direction comes straight from the request on the accept edge.
    w_write_sel  = w_accept ? req_write : r_write;
    w_bus_active = (w_state_next inside {ADDR, SETUP, CMD, WAIT, HOLD});
    w_cmd_active = (w_state_next inside {CMD, WAIT});

    // Address and write data are loaded on accept, held through HOLD, then parked.
    if (w_accept) begin
      w_isa_addr_next   = req_addr;
      w_isa_data_o_next = req_write ? req_wdata : ISA_DATA_PARK;
    end else if (w_bus_active) begin
      w_isa_addr_next   = r_isa_addr;
      w_isa_data_o_next = r_isa_data_o;
    end else begin
      w_isa_addr_next   = ISA_ADDR_PARK;
      w_isa_data_o_next = ISA_DATA_PARK;
    end

    w_isa_data_oe_next = w_bus_active && w_write_sel;
    w_bale_next        = (w_state_next == ADDR);
    w_mem_r_next       = !(w_cmd_active && !w_write_sel);
    w_mem_w_next       = !(w_cmd_active && w_write_sel);
    w_req_ready_next   = (w_state_next == IDLE);
    w_busy_next        = (w_state_next != IDLE);

    // Response is a single pulse on HOLD entry; the timeout flag only rides it.
    w_rsp_valid_next   = w_to_hold;
    w_rsp_timeout_next = w_to_hold && w_timeout;
    if (w_to_hold && !r_write) begin
      w_rsp_rdata_next = w_timeout ? ISA_DATA_PARK : isa_data_i;
    end else begin
      w_rsp_rdata_next = r_rsp_rdata;
    end
  end

  // State, counter and output registers; reset releases the command and parks the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_write       <= 1'b0;
      r_isa_addr    <= ISA_ADDR_PARK;
      r_isa_data_o  <= ISA_DATA_PARK;
      r_isa_data_oe <= 1'b0;
      r_bale        <= 1'b0;
      r_mem_r       <= 1'b1;
      r_mem_w       <= 1'b1;
      r_req_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= ISA_DATA_PARK;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_write       <= w_write_sel;
      r_isa_addr    <= w_isa_addr_next;
      r_isa_data_o  <= w_isa_data_o_next;
      r_isa_data_oe <= w_isa_data_oe_next;
      r_bale        <= w_bale_next;
      r_mem_r       <= w_mem_r_next;
      r_mem_w       <= w_mem_w_next;
      r_req_ready   <= w_req_ready_next;
      r_busy        <= w_busy_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_timeout <= w_rsp_timeout_next;
      r_rsp_rdata   <= w_rsp_rdata_next;
    end
  end

  assign isa_addr    = r_isa_addr;
  assign isa_data_o  = r_isa_data_o;
  assign isa_data_oe = r_isa_data_oe;
  assign bale        = r_bale;
  assign mem_r       = r_mem_r;
  assign mem_w       = r_mem_w;
  assign req_ready   = r_req_ready;
  assign busy        = r_busy;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_isa_cycle_engine.sv
// Bench for isa_cycle_engine. Each access is predicted from the phase
// lengths and the IOCHRDY waveform: cycle n counts from the accept edge,
// the synchronized ready seen in cycle n is io_chrdy from cycle n-2.
module tb_isa_cycle_engine;

  localparam int B = 2;
  localparam int S = 2;
  localparam int C = 6;
  localparam int H = 2;
  localparam int R = 4;
  localparam int T = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [23:0] isa_addr;
  logic [7:0]  isa_data_o;
  logic        isa_data_oe;
  logic [7:0]  isa_data_i;
  logic        bale;
  logic        mem_r;
  logic        mem_w;
  logic        io_chrdy;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  isa_cycle_engine dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .isa_addr    (isa_addr),
    .isa_data_o  (isa_data_o),
    .isa_data_oe (isa_data_oe),
    .isa_data_i  (isa_data_i),
    .bale        (bale),
    .mem_r       (mem_r),
    .mem_w       (mem_w),
    .io_chrdy    (io_chrdy),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // io_chrdy driven in cycle k: low inside [lo,hi], high elsewhere.
  function automatic bit io_lvl(input int k, input int lo, input int hi);
    return !(k >= lo && k <= hi);
  endfunction

  // Synchronized ready as the engine sees it in cycle n.
  function automatic bit cs_lvl(input int n, input int lo, input int hi);
    if (n - 2 <= 0) return 1'b1;
    return io_lvl(n - 2, lo, hi);
  endfunction

  // One complete access, checked cycle by cycle until the engine is idle again.
  task automatic run_txn(input bit wr, input logic [23:0] a, input logic [7:0] wd,
                         input logic [7:0] bus, input int lo, input int hi, input bit keep_valid);
    int   waited;
    int   cmd_start, last_cmd, hold_start, recov_start, idle_start;
    bit   to_exp;
    bit   cmd_low;
    logic [7:0] rd_exp;

    waited = 0;
    while (req_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_req", 0, req_ready, 1'b1);

    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = wd;
    isa_data_i = bus;
    io_chrdy   = 1'b1;

    cmd_start = 1 + B + S;
    last_cmd  = cmd_start + C - 1;
    to_exp    = 1'b0;
    if (cs_lvl(last_cmd, lo, hi)) begin
      hold_start = last_cmd + 1;
    end else begin
      hold_start = last_cmd + T + 1;
      to_exp     = 1'b1;
      for (int w = last_cmd + 1; w <= last_cmd + T; w++) begin
        if (cs_lvl(w, lo, hi)) begin
          hold_start = w + 1;
          to_exp     = 1'b0;
          break;
        end
      end
    end
    recov_start = hold_start + H;
    idle_start  = recov_start + R;
    rd_exp      = to_exp ? 8'hFF : bus;

    @(posedge clk);
    for (int c = 1; c <= idle_start; c++) begin
      @(negedge clk);
      if (!keep_valid) req_valid = 1'b0;
      io_chrdy = io_lvl(c, lo, hi);
      cmd_low  = (c >= cmd_start) && (c < hold_start);
      check("bale", c, bale, (c <= B));
      check("mem_r", c, mem_r, !(cmd_low && !wr));
      check("mem_w", c, mem_w, !(cmd_low && wr));
      check("data_oe", c, isa_data_oe, wr && (c < recov_start));
      check("isa_addr", c, isa_addr, (c < recov_start) ? a : 24'hFFFFFF);
      if (wr && c < recov_start) check("isa_data_o", c, isa_data_o, wd);
      check("busy", c, busy, (c < idle_start));
      check("req_ready", c, req_ready, (c >= idle_start));
      check("rsp_valid", c, rsp_valid, (c == hold_start));
      check("rsp_timeout", c, rsp_timeout, (c == hold_start) && to_exp);
      if (c == hold_start && !wr) check("rsp_rdata", c, rsp_rdata, rd_exp);
      check("no_dual_cmd", c, (!mem_r && !mem_w), 1'b0);
      check("bale_vs_cmd", c, (bale && (!mem_r || !mem_w)), 1'b0);
    end
    $display("TXN wr=%0d addr=%06h wdata=%02h bus=%02h chrdy_low=[%0d,%0d] rsp_cycle=%0d timeout=%0d",
             wr, a, wd, bus, lo, hi, hold_start, to_exp);
  endtask

  initial begin
    logic [23:0] ra;
    logic [7:0]  rd;
    logic [7:0]  rb;
    bit          rw;
    int          rlo;
    int          rhi;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 24'h0;
    req_wdata  = 8'h0;
    isa_data_i = 8'h00;
    io_chrdy   = 1'b1;

    // Reset values after the first edge with rst high.
    @(posedge clk);
    @(negedge clk);
    check("rst_addr", 0, isa_addr, 24'hFFFFFF);
    check("rst_data_o", 0, isa_data_o, 8'hFF);
    check("rst_oe", 0, isa_data_oe, 1'b0);
    check("rst_bale", 0, bale, 1'b0);
    check("rst_mem_r", 0, mem_r, 1'b1);
    check("rst_mem_w", 0, mem_w, 1'b1);
    check("rst_ready", 0, req_ready, 1'b1);
    check("rst_rsp_valid", 0, rsp_valid, 1'b0);
    check("rst_rdata", 0, rsp_rdata, 8'hFF);
    check("rst_timeout", 0, rsp_timeout, 1'b0);
    check("rst_busy", 0, busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed: plain write, plain read, ready held low, late low, stuck low.
    run_txn(1'b1, 24'h0D8123, 8'hA5, 8'h00, 1, 0, 1'b0);
    run_txn(1'b0, 24'h0D8000, 8'h00, 8'h3C, 1, 0, 1'b0);
    rb = 8'($urandom);
    run_txn(1'b0, 24'h0D8040, 8'h00, rb, 3, 20, 1'b0);
    run_txn(1'b0, 24'h0D8041, 8'h00, 8'h96, 9, 30, 1'b0);
    run_txn(1'b0, 24'h0D8002, 8'h00, 8'h5A, 1, 1000000, 1'b0);
    run_txn(1'b1, 24'h0D8003, 8'h7E, 8'h00, 1, 0, 1'b0);

    // Back-to-back with req_valid held high across both requests.
    run_txn(1'b1, 24'h0C0001, 8'h11, 8'h00, 1, 0, 1'b1);
    run_txn(1'b0, 24'h0C0002, 8'h00, 8'hC3, 1, 0, 1'b0);

    // Randomized accesses with random IOCHRDY stretches.
    for (int i = 0; i < 8; i++) begin
      rw  = 1'($urandom_range(0, 1));
      ra  = 24'($urandom);
      rd  = 8'($urandom);
      rb  = 8'($urandom);
      rlo = $urandom_range(3, 14);
      rhi = ($urandom_range(0, 3) == 0) ? rlo - 1 : rlo + $urandom_range(0, 40);
      run_txn(rw, ra, rd, rb, rlo, rhi, 1'b0);
    end

    // Reset during the CMD phase of a write.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'h0D8200;
    req_wdata = 8'h42;
    io_chrdy  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check("pre_rst_mem_w", 7, mem_w, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_w", 8, mem_w, 1'b1);
    check("midrst_mem_r", 8, mem_r, 1'b1);
    check("midrst_oe", 8, isa_data_oe, 1'b0);
    check("midrst_addr", 8, isa_addr, 24'hFFFFFF);
    check("midrst_ready", 8, req_ready, 1'b1);
    check("midrst_busy", 8, busy, 1'b0);
    check("midrst_rsp_valid", 8, rsp_valid, 1'b0);
    rst = 1'b0;
    for (int c = 9; c <= 30; c++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", c, rsp_valid, 1'b0);
      check("post_rst_mem_w", c, mem_w, 1'b1);
    end
    $display("TXN reset-abort write addr=0d8200 rst_cycle=7");

    // Engine still serves a normal access after the abort.
    run_txn(1'b0, 24'h0D8300, 8'h00, 8'h81, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/isa_cycle_engine.md
Name: isa_cycle_engine

Overview:
- Downstream ISA-side stage of the PC104/Duagon CPLD bridge.
- Accepts one decoded ARM access request at a time: 24-bit memory address, direction and 8-bit write data.
- Runs a complete, timed 8-bit ISA memory cycle (BALE, MEMR#/MEMW#, IOCHRDY wait extension, hold, recovery) and returns read data and status to the ARM-side interface.
- Replaces free-running clock-divider sequencing with one counter-driven FSM on the 50 MHz system clock.

Parameters:
- BALE_CYC, 2, clk cycles BALE is high, with address driven.
- SETUP_CYC, 2, clk cycles BALE is low and address stable before the command asserts.
- CMD_CYC, 6, minimum clk cycles MEMR#/MEMW# is low.
- HOLD_CYC, 2, clk cycles address/write data are held after the command deasserts.
- RECOV_CYC, 4, idle clk cycles between consecutive ISA cycles.
- TIMEOUT_CYC, 256, maximum WAIT-state clk cycles before forced termination.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  access request present
- req_ready  out  1  engine can accept a request this cycle
- req_write  in  1  1 = memory write, 0 = memory read
- req_addr  in  24  ISA memory address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: access finished
- rsp_rdata  out  8  read data; valid with rsp_valid
- rsp_timeout  out  1  qualifies rsp_valid: cycle ended by timeout
- isa_addr  out  24  ISA address bus
- isa_data_o  out  8  ISA write data
- isa_data_oe  out  1  ISA data driver enable; also transceiver DIR
- isa_data_i  in  8  ISA data bus input
- bale  out  1  bus address latch enable
- mem_r  out  1  MEMR#, active low
- mem_w  out  1  MEMW#, active low
- io_chrdy  in  1  IOCHRDY, asynchronous; low = extend cycle
- busy  out  1  high whenever state != IDLE; drives ARM wait

Behaviour:
- Reset values, applied on the first rising clk with rst=1:
  - state=IDLE, isa_addr=24'hFFFFFF, isa_data_o=8'hFF, isa_data_oe=0
  - bale=0, mem_r=1, mem_w=1
  - req_ready=1, rsp_valid=0, rsp_rdata=8'hFF, rsp_timeout=0, busy=0
  - Reset mid-cycle: the command is released and the bus parked in the same edge; no rsp_valid is issued for the aborted access.
- io_chrdy passes through a 2-flop synchronizer; only the synchronized chrdy_s is used.
- A single counter is loaded with (phase length − 1) on every state entry and decrements to 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch addr/write/wdata, go to ADDR. Requests are never accepted outside IDLE.
  - ADDR: isa_addr=latched addr, bale=1, isa_data_oe=write flag. Lasts BALE_CYC cycles, then SETUP.
  - SETUP: bale=0, address and data held. Lasts SETUP_CYC cycles, then CMD.
  - CMD: mem_r=0 (read) or mem_w=0 (write). Lasts CMD_CYC cycles. In the last cycle, chrdy_s=1 goes to HOLD; chrdy_s=0 goes to WAIT.
  - WAIT: command held low. Exits to HOLD in the cycle chrdy_s=1 is seen. After TIMEOUT_CYC cycles with chrdy_s=0, exits to HOLD with the timeout flag set.
  - HOLD: command deasserted. Address and data held. Lasts HOLD_CYC cycles.
  - RECOV: isa_addr=24'hFFFFFF, isa_data_oe=0. Lasts RECOV_CYC cycles, then IDLE.
- Read capture: rsp_rdata captures isa_data_i on the edge leaving CMD/WAIT. On timeout, rsp_rdata=8'hFF.
- Response: rsp_valid=1 for exactly the first HOLD cycle. rsp_timeout is valid only then and cleared otherwise.
- Latency with no wait states and defaults:
  - Accept edge E0; ADDR cycles 1–2; SETUP 3–4; CMD 5–10.
  - rsp_valid in cycle 11; HOLD 11–12; RECOV 13–16.
  - req_ready=1 from cycle 17.
- Invariants:
  - mem_r and mem_w are never both low.
  - bale is never high while a command is low.
  - isa_data_oe is never high during a read.
- io_chrdy going low only after the last CMD cycle has no effect.
- Parameter values of 0 are illegal. Minimum for all is 1.

Decomposition:
- Package isa_pkg holds:
  - the FSM state encoding: IDLE, ADDR, SETUP, CMD, WAIT, HOLD, RECOV (3-bit)
  - ISA_ADDR_PARK=24'hFFFFFF
  - default timing constants
  - the counter width, derived as the clog2 of TIMEOUT_CYC
- Sub-module isa_sync: parameterised 2-flop synchronizer with reset value 1, instanced for io_chrdy.

Test Plan:
- Write 0xA5 to 0x0D8123, chrdy held 1:
  - bale high for cycles 1–2
  - mem_w low for cycles 5–10
  - isa_data_o=0xA5 with oe=1 for cycles 1–12
  - rsp_valid in cycle 11, rsp_timeout=0
  - bus parked at 0xFFFFFF in cycle 13
- Read 0x0D8000, bus returns 0x3C:
  - mem_r low for cycles 5–10
  - rsp_rdata=0x3C, rsp_timeout=0
  - isa_data_oe=0 throughout
- Read with io_chrdy low from cycle 3 to cycle 20:
  - mem_r stays low until 2 cycles after io_chrdy rises
  - correct data captured
  - rsp_valid one cycle after that
- io_chrdy stuck low:
  - WAIT lasts 256 cycles, then mem_r releases
  - rsp_valid=1, rsp_timeout=1, rsp_rdata=0xFF
  - the next request completes normally
- Back-to-back: req_valid held high with two requests:
  - the second is accepted only in cycle 17 (after RECOV)
  - its ADDR phase starts in cycle 18
  - busy is low only in cycle 17
- rst asserted in cycle 7 (CMD of a write):
  - on the next edge mem_w=1, oe=0, addr=0xFFFFFF, req_ready=1
  - no rsp_valid pulse
